// File: rtl/servo_sched_pkg.sv
// servo_sched_pkg: shared state encoding, command bundle and defaults for the servo scan sequencer
package servo_sched_pkg;
  localparam int PWM_PERIOD_DEF = 2000000;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_SWEEP,
    S_DWELL,
    S_STEP,
    S_ABORT,
    S_RETURN
  } state_t;
  typedef struct packed {
    logic x_fwd;
    logic x_rev;
    logic x_neu;
    logic x_zero;
    logic x_rtz;
    logic y_fwd;
    logic y_neu;
    logic y_zero;
    logic y_rtz;
    logic done;
  } cmd_t;
  function automatic logic abortable(input state_t s);
    return s inside {S_ALIGN, S_SWEEP, S_DWELL, S_STEP};
  endfunction
endpackage

// File: rtl/period_tick_gen.sv
// period_tick_gen: free-running PWM period counter with a one-cycle tick on its last count
module period_tick_gen #(
  parameter int PWM_PERIOD = 2000000
) (
  input  logic PCLK,
  input  logic PRESET,
  output logic o_tick
);
  localparam int W = PWM_PERIOD > 1 ? $clog2(PWM_PERIOD) : 1;
  logic [W-1:0] r_cnt;
  assign o_tick = r_cnt == W'(PWM_PERIOD - 1);
  always_ff @(posedge PCLK) r_cnt <= PRESET || o_tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/servo_scan_sequencer.sv
// servo_scan_sequencer: PWM-aligned boustrophedon pan/tilt raster scan; define SCAN_DWELL_EN for a neutral dwell after each sweep
module servo_scan_sequencer
  import servo_sched_pkg::*;
#(
  parameter int PWM_PERIOD = PWM_PERIOD_DEF,
  parameter int CNT_W = CNT_W_DEF
`ifdef SCAN_DWELL_EN
  , parameter int DWELL_PERIODS = 2
`endif
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       cfg_rows,
  input  logic [CNT_W-1:0] cfg_row_periods,
  input  logic [CNT_W-1:0] cfg_step_periods,
  input  logic [CNT_W-1:0] cfg_rtz_periods,
  output logic             x_fwd,
  output logic             x_rev,
  output logic             x_neu,
  output logic             x_zero,
  output logic             x_rtz,
  output logic             y_fwd,
  output logic             y_neu,
  output logic             y_zero,
  output logic             y_rtz,
  output logic             busy,
  output logic             done,
  output logic [7:0]       row_idx
);
  state_t r_state, w_nxt;
  cmd_t r_cmd, w_cmd;
  logic [CNT_W-1:0] r_cnt, w_cnt, r_row_ld, r_step_ld, r_rtz_ld;
  logic [7:0] r_rows, r_row, w_row;
  logic r_busy, w_tick, w_accept, w_last, w_final;
  function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] p);
    return p == '0 ? '0 : p - 1'b1;
  endfunction
  period_tick_gen #(.PWM_PERIOD(PWM_PERIOD)) u_tick (
    .PCLK(PCLK),
    .PRESET(PRESET),
    .o_tick(w_tick)
  );
  assign w_accept = r_state == S_IDLE && start && !abort;
  assign w_last = r_cnt == '0;
  assign w_final = r_row == r_rows - 8'd1;
  assign {x_fwd, x_rev, x_neu, x_zero, x_rtz, y_fwd, y_neu, y_zero, y_rtz, done} = r_cmd;
  assign busy = r_busy;
  assign row_idx = r_row;
  always_comb begin
    w_nxt = r_state;
    w_cnt = r_cnt;
    w_row = r_row;
    w_cmd = '0;
    if (w_tick && !w_last) w_cnt = r_cnt - 1'b1;
    if (abort && abortable(r_state)) begin
      w_nxt = S_ABORT;
      w_cmd.x_neu = 1'b1;
      w_cmd.y_neu = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: if (w_accept) begin
          w_row = '0;
          w_nxt = cfg_rows == '0 ? S_IDLE : S_ALIGN;
          w_cmd.done = cfg_rows == '0;
          w_cmd.x_zero = cfg_rows != '0;
          w_cmd.y_zero = cfg_rows != '0;
        end
        S_ALIGN: if (w_tick) begin
          w_nxt = S_SWEEP;
          w_cnt = r_row_ld;
          w_row = '0;
          w_cmd.x_fwd = 1'b1;
        end
        S_SWEEP: if (w_tick && w_last) begin
          w_cmd.x_neu = 1'b1;
          if (w_final) begin
            w_nxt = S_RETURN;
            w_cnt = r_rtz_ld;
            w_cmd.x_rtz = 1'b1;
            w_cmd.y_rtz = 1'b1;
          end else begin
`ifdef SCAN_DWELL_EN
            w_nxt = S_DWELL;
            w_cnt = CNT_W'(DWELL_PERIODS > 0 ? DWELL_PERIODS - 1 : 0);
`else
            w_nxt = S_STEP;
            w_cnt = r_step_ld;
            w_cmd.y_fwd = 1'b1;
`endif
          end
        end
`ifdef SCAN_DWELL_EN
        S_DWELL: if (w_tick && w_last) begin
          w_nxt = S_STEP;
          w_cnt = r_step_ld;
          w_cmd.y_fwd = 1'b1;
        end
`endif
        S_STEP: if (w_tick && w_last) begin
          w_nxt = S_SWEEP;
          w_cnt = r_row_ld;
          w_row = r_row + 8'd1;
          w_cmd.y_neu = 1'b1;
          w_cmd.x_fwd = !w_row[0];
          w_cmd.x_rev = w_row[0];
        end
        S_ABORT: if (w_tick) begin
          w_nxt = S_RETURN;
          w_cnt = r_rtz_ld;
          w_cmd.x_rtz = 1'b1;
          w_cmd.y_rtz = 1'b1;
        end
        S_RETURN: if (w_tick && w_last) begin
          w_nxt = S_IDLE;
          w_cmd.done = 1'b1;
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state <= S_IDLE;
      r_cmd <= '0;
      r_cnt <= '0;
      r_row <= '0;
      r_busy <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cmd <= w_cmd;
      r_cnt <= w_cnt;
      r_row <= w_row;
      r_busy <= w_nxt != S_IDLE;
    end
  end
  // a zero period count is latched as a one-period count
  always_ff @(posedge PCLK) begin
    if (w_accept) begin
      r_rows <= cfg_rows;
      r_row_ld <= ld(cfg_row_periods);
      r_step_ld <= ld(cfg_step_periods);
      r_rtz_ld <= ld(cfg_rtz_periods);
    end
  end
endmodule

// File: tb/tb_servo_scan_sequencer.sv
// tb_servo_scan_sequencer: schedule-based reference model of the raster scan checked every cycle against the sequencer
module tb_servo_scan_sequencer;
  localparam int P = 100;
`ifdef SCAN_DWELL_EN
  localparam int DW = 2;
`else
  localparam int DW = 0;
`endif
  localparam logic [9:0] XF = 10'b1000000000;
  localparam logic [9:0] XR = 10'b0100000000;
  localparam logic [9:0] XN = 10'b0010000000;
  localparam logic [9:0] XZ = 10'b0001000000;
  localparam logic [9:0] XT = 10'b0000100000;
  localparam logic [9:0] YF = 10'b0000010000;
  localparam logic [9:0] YN = 10'b0000001000;
  localparam logic [9:0] YZ = 10'b0000000100;
  localparam logic [9:0] YT = 10'b0000000010;
  localparam logic [9:0] DN = 10'b0000000001;
  logic PCLK = 1'b0;
  logic PRESET = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] cfg_rows = '0;
  logic [15:0] cfg_row_periods = '0, cfg_step_periods = '0, cfg_rtz_periods = '0;
  logic x_fwd, x_rev, x_neu, x_zero, x_rtz, y_fwd, y_neu, y_zero, y_rtz, busy, done;
  logic [7:0] row_idx;
  int cyc = 0, c0 = 0, b_lo = 0, b_hi = 0, checks = 0, failures = 0;
  bit chk_en = 0;
  logic [9:0] exp_ev[int];
  int row_at[int];

  servo_scan_sequencer #(.PWM_PERIOD(P)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .start(start), .abort(abort),
    .cfg_rows(cfg_rows), .cfg_row_periods(cfg_row_periods),
    .cfg_step_periods(cfg_step_periods), .cfg_rtz_periods(cfg_rtz_periods),
    .x_fwd(x_fwd), .x_rev(x_rev), .x_neu(x_neu), .x_zero(x_zero), .x_rtz(x_rtz),
    .y_fwd(y_fwd), .y_neu(y_neu), .y_zero(y_zero), .y_rtz(y_rtz),
    .busy(busy), .done(done), .row_idx(row_idx)
  );

  always #5 PCLK = ~PCLK;

  // first cycle after c whose period phase is the last count
  function automatic int next_tick(int c);
    int t;
    t = c + 1;
    while ((t - c0) % P != P - 1) t++;
    return t;
  endfunction

  function automatic void add(int k, logic [9:0] v);
    exp_ev[k] = exp_ev.exists(k) ? (exp_ev[k] | v) : v;
  endfunction

  function automatic void trim(int k);
    int q[$];
    foreach (exp_ev[i]) if (i > k) q.push_back(i);
    foreach (q[j]) exp_ev.delete(q[j]);
    q.delete();
    foreach (row_at[i]) if (i > k) q.push_back(i);
    foreach (q[j]) row_at.delete(q[j]);
  endfunction

  // expected command timeline for a start seen in cycle c, optional abort in cycle ab
  function automatic void plan(int c, int rows, int rp, int sp, int rtz, int ab);
    int t, e, ret, dn;
    rp = rp == 0 ? 1 : rp;
    sp = sp == 0 ? 1 : sp;
    rtz = rtz == 0 ? 1 : rtz;
    if (rows == 0) begin
      add(c + 1, DN);
      b_lo = c + 1;
      b_hi = c + 1;
      return;
    end
    add(c + 1, XZ | YZ);
    t = next_tick(c);
    e = t;
    for (int r = 0; r < rows; r++) begin
      add(t + 1, r % 2 == 1 ? XR : XF);
      row_at[t + 1] = r;
      e = t + P * rp;
      add(e + 1, XN);
      if (r < rows - 1) begin
        t = e + P * DW;
        add(t + 1, YF);
        t = t + P * sp;
        add(t + 1, YN);
      end
    end
    ret = e + 1;
    add(ret, XT | YT);
    dn = e + P * rtz + 1;
    if (ab > c && ab < ret) begin
      trim(ab);
      add(ab + 1, XN | YN);
      t = next_tick(ab);
      add(t + 1, XT | YT);
      dn = t + P * rtz + 1;
    end
    add(dn, DN);
    b_lo = c + 1;
    b_hi = dn;
  endfunction

  task automatic do_rst();
    PRESET = 1'b1;
    c0 = cyc + 1;
    trim(cyc);
    if (b_hi > cyc + 1) b_hi = cyc + 1;
    row_at[cyc + 1] = 0;
    chk_en = 1;
  endtask

  task automatic step();
    logic [9:0] obs, ex;
    logic eb;
    @(posedge PCLK);
    cyc++;
    @(negedge PCLK);
    start = 1'b0;
    abort = 1'b0;
    PRESET = 1'b0;
    if (chk_en) begin
      obs = {x_fwd, x_rev, x_neu, x_zero, x_rtz, y_fwd, y_neu, y_zero, y_rtz, done};
      ex = exp_ev.exists(cyc) ? exp_ev[cyc] : 10'b0;
      eb = cyc >= b_lo && cyc < b_hi;
      checks++;
      assert (obs === ex) else begin
        failures++;
        $error("FAIL cmd cyc=%0d got=%b want=%b", cyc, obs, ex);
      end
      checks++;
      assert (busy === eb) else begin
        failures++;
        $error("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, eb);
      end
      if (row_at.exists(cyc)) begin
        checks++;
        assert (row_idx === 8'(row_at[cyc])) else begin
          failures++;
          $error("FAIL row_idx cyc=%0d got=%0d want=%0d", cyc, row_idx, row_at[cyc]);
        end
      end
    end
  endtask

  // event offsets are relative to the first tick after start; -1 disables
  task automatic scan(int rows, int rp, int sp, int rtz, int ab_rel, int rs_rel, int ms_rel);
    int c, t1, ab, rs, ms, stop;
    step();
    c = cyc;
    t1 = next_tick(c);
    ab = ab_rel < 0 ? -1 : t1 + ab_rel;
    rs = rs_rel < 0 ? -1 : t1 + rs_rel;
    ms = ms_rel < 0 ? -1 : t1 + ms_rel;
    cfg_rows = 8'(rows);
    cfg_row_periods = 16'(rp);
    cfg_step_periods = 16'(sp);
    cfg_rtz_periods = 16'(rtz);
    start = 1'b1;
    plan(c, rows, rp, sp, rtz, ab);
    stop = (b_hi > c + 2 ? b_hi : c + 2) + 3;
    while (cyc < stop) begin
      step();
      if (cyc == c + 1) begin
        cfg_rows = 8'($urandom);
        cfg_row_periods = 16'($urandom);
        cfg_step_periods = 16'($urandom);
        cfg_rtz_periods = 16'($urandom);
      end
      if (cyc == ab) abort = 1'b1;
      if (cyc == ms) start = 1'b1;
      if (cyc == rs) begin
        do_rst();
        stop = cyc + 4;
      end
    end
  endtask

  initial begin
    do_rst();
    step();
    do_rst();
    repeat (4) step();
    scan(2, 3, 1, 4, -1, -1, 250);
    while ((cyc + 1 - c0) % P != P - 1) step();
    scan(1, 1, 1, 1, -1, -1, -1);
    scan(3, 3, 1, 4, P * (3 + DW + 1) + 150, -1, -1);
    scan(0, 3, 1, 4, -1, -1, -1);
    step();
    cfg_rows = 8'd2;
    start = 1'b1;
    abort = 1'b1;
    repeat (150) step();
    step();
    abort = 1'b1;
    repeat (3) step();
    scan(1, 1, 1, 2, P + 50, -1, -1);
    scan(2, 1, 3, 1, -1, P * (1 + DW) + 150, -1);
    scan(2, 1, 1, 1, -1, -1, -1);
    scan(1, 0, 0, 0, 0, -1, -1);
    for (int i = 0; i < 6; i++) begin
      scan(int'($urandom_range(1, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
           int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1 ? int'($urandom_range(0, P * 8)) : -1,
           -1, -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
